// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: returns the word at a fetch byte address after a
// fixed LATENCY, stalling new requests while one is in flight; loader port fills the array.
`timescale 1ns/1ps
module imem_fetch_responder #(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [15:0] addr,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic [15:0] data_out,
    output logic        done,
    output logic        err,
    output logic        stall,
    output logic        busy
);

    localparam int         IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("imem_fetch_responder: LATENCY must be within 1..15");
        end
        if (MEM_WORDS < 2 || MEM_WORDS > 32768 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
            $error("imem_fetch_responder: MEM_WORDS must be a power of two within 2..32768");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_nx;
    logic [3:0]         count, count_nx;
    logic [15:0]        mem [MEM_WORDS];
    logic [IDX_W-1:0]   rd_idx, ld_idx;
    logic [15:0]        rd_word;
    logic [15:0]        snap_data;
    logic               snap_err;
    logic               accept;
    logic               unused_bits;

    // Byte addresses map to word indices; high bits beyond the array simply wrap.
    assign rd_idx      = addr[IDX_W:1];
    assign ld_idx      = ld_addr[IDX_W:1];
    assign rd_word     = addr[0] ? 16'h0000 : mem[rd_idx];
    assign accept      = rd_en & ~stall;
    assign unused_bits = ^{addr, ld_addr};

    // NOTE: the array carries no reset; it keeps its contents across rst so the
    // loader image survives, and this lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
    end

    // NOTE: non-blocking writes mean a read accepted on the same edge as a write
    // to that word sees the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        count_nx = LAT_M1;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                count_nx = count - 4'd1;
                if (count == 4'd1) state_nx = RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == RESP);
        stall = rd_en & busy & ~done;
    end

    // Snapshot at accept; the response registers change only on entry to RESP so
    // data_out holds the previous response while a fetch is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_data <= 16'h0000;
            snap_err  <= 1'b0;
            data_out  <= 16'h0000;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                snap_data <= rd_word;
                snap_err  <= addr[0];
            end
            if (state_nx == RESP) begin
                data_out <= accept ? rd_word : snap_data;
                err      <= accept ? addr[0] : snap_err;
            end else begin
                err      <= 1'b0;
            end
        end
    end

endmodule
